// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, transmit-queue defaults and the
// issue-controller state encoding.
package uart_pkg;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned TXQ_DEPTH_DEF = 16;
    localparam int unsigned TXQ_STOP_DEF  = 1;

    typedef enum logic [1:0] {
        TXQ_IDLE      = 2'd0,
        TXQ_ISSUE     = 2'd1,
        TXQ_WAIT_BUSY = 2'd2,
        TXQ_WAIT_DONE = 2'd3
    } txq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// DEPTH x 8 byte FIFO with read/write pointers, occupancy count and
// FULL/EMPTY flags derived from the registered count. The head byte is
// presented combinationally on head.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = TXQ_DEPTH_DEF
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    input  logic                     push_req,
    input  logic                     pop,
    output logic [UART_BYTE_W-1:0]   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_wr;
    logic                   do_rd;

    // A push while full is dropped outright, even when a pop frees a slot
    // on the same edge.
    always_comb begin
        do_wr = push_req && !full;
        do_rd = pop && !empty;
        head  = mem[rd_ptr];
        full  = (count == FULL_CNT);
        empty = (count == '0);
    end

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge sysclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and issue controller feeding the UART transmitter.
// Bytes are queued one per cycle and handed over one at a time with a
// single-cycle TX_EN pulse, pacing on TX_STATUS (1 = transmitter idle) and
// holding STOP_CYCLES extra idle cycles between frames.
// Optional feature macro: UART_TXQ_LEVEL_EN adds the LEVEL occupancy port.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = TXQ_DEPTH_DEF,
    parameter int unsigned STOP_CYCLES = TXQ_STOP_DEF
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic [7:0]             WR_DATA,
    input  logic                   WR_EN,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [7:0]             TX_DATA,
    output logic                   TX_EN,
    input  logic                   TX_STATUS,
    output logic                   BUSY
`ifdef UART_TXQ_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] LEVEL
`endif
);

    localparam logic [3:0] GAP_INIT = 4'(STOP_CYCLES);

    txq_state_t             state;
    logic [3:0]             gap;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head;
    logic [$clog2(DEPTH):0] level_q;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sysclk   (sysclk),
        .reset    (reset),
        .wr_data  (WR_DATA),
        .push_req (WR_EN),
        .pop      (pop),
        .head     (head),
        .full     (FULL),
        .empty    (EMPTY),
        .count    (level_q)
    );

`ifdef UART_TXQ_LEVEL_EN
    assign LEVEL = level_q;
`else
    logic unused_level;
    assign unused_level = ^level_q;
`endif

    // Issue decision: the only point where the queue is popped.
    always_comb begin
        pop  = (state == TXQ_IDLE) && !EMPTY && TX_STATUS && (gap == '0);
        BUSY = !EMPTY || (state != TXQ_IDLE);
    end

    // Issue FSM with registered TX_EN/TX_DATA and the inter-frame gap counter.
    // WAIT_BUSY must see TX_STATUS drop before the frame can be considered
    // started, so a transmitter that has not yet reacted is never re-issued.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= TXQ_IDLE;
            TX_EN   <= 1'b0;
            TX_DATA <= '0;
            gap     <= '0;
        end else begin
            TX_EN <= 1'b0;
            case (state)
                TXQ_IDLE: begin
                    if (pop) begin
                        TX_DATA <= head;
                        TX_EN   <= 1'b1;
                        state   <= TXQ_ISSUE;
                    end else if (gap != '0) begin
                        gap <= gap - 4'd1;
                    end
                end
                TXQ_ISSUE: begin
                    state <= TXQ_WAIT_BUSY;
                end
                TXQ_WAIT_BUSY: begin
                    if (!TX_STATUS) begin
                        state <= TXQ_WAIT_DONE;
                    end
                end
                TXQ_WAIT_DONE: begin
                    if (TX_STATUS) begin
                        state <= TXQ_IDLE;
                        gap   <= GAP_INIT;
                    end
                end
                default: begin
                    state <= TXQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue (DEPTH=4, STOP_CYCLES=1) paired with
// a behavioural one-bit-per-cycle transmitter model.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int STOP  = 1;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] WR_DATA = 8'h00;
    logic       WR_EN   = 1'b0;
    logic       FULL, EMPTY, TX_EN, BUSY, TX_STATUS;
    logic [7:0] TX_DATA;
`ifdef UART_TXQ_LEVEL_EN
    logic [2:0] LEVEL;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .STOP_CYCLES (STOP)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .WR_DATA   (WR_DATA),
        .WR_EN     (WR_EN),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .BUSY      (BUSY)
`ifdef UART_TXQ_LEVEL_EN
        ,
        .LEVEL     (LEVEL)
`endif
    );

    always #5 sysclk = ~sysclk;

    // ---------------- transmitter model ----------------
    logic       xm_status = 1'b1;
    logic       xm_busy   = 1'b0;
    logic       tx_line   = 1'b1;
    logic [7:0] xm_sh     = 8'h00;
    int         xm_bit    = 0;
    int         xm_cyc    = 0;
    logic       force_low  = 1'b0;
    logic       force_high = 1'b0;
    logic [7:0] rx_q[$];
    int         accept_cyc[$];

    assign TX_STATUS = force_low ? 1'b0 : (force_high ? 1'b1 : xm_status);

    always @(posedge sysclk) begin
        xm_cyc <= xm_cyc + 1;
        if (!xm_busy) begin
            if (TX_EN && TX_STATUS && !force_high) begin
                xm_busy   <= 1'b1;
                xm_status <= 1'b0;
                tx_line   <= 1'b0;
                xm_sh     <= TX_DATA;
                xm_bit    <= 0;
                rx_q.push_back(TX_DATA);
                accept_cyc.push_back(xm_cyc);
            end
        end else if (xm_bit < 8) begin
            tx_line <= xm_sh[xm_bit];
            xm_bit  <= xm_bit + 1;
        end else begin
            tx_line   <= 1'b1;
            xm_status <= 1'b1;
            xm_busy   <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // phase: 0 = may issue, 1 = issued and waiting for transmitter to go busy,
    // 2 = waiting for transmitter to finish.
    logic [7:0] ref_q[$];
    logic [7:0] exp_issue_q[$];
    int         cyc = 0;
    int         phase = 0;
    int         issue_cyc = 0;
    int         earliest = 0;
    bit         full_pre;
    logic       pred_en = 1'b0;
    logic [7:0] pred_byte = 8'h00;
    logic [7:0] exp_txd = 8'h00;
    bit         mon_en = 1'b0;
    int         en_cnt = 0;

    always @(posedge sysclk) begin
        cyc++;
        if (reset) begin
            ref_q.delete();
            phase    = 0;
            earliest = 0;
            pred_en  = 1'b0;
            exp_txd  = 8'h00;
        end else begin
            full_pre = (ref_q.size() == DEPTH);
            pred_en  = 1'b0;
            case (phase)
                0: if (ref_q.size() != 0 && TX_STATUS && cyc >= earliest) begin
                    pred_en   = 1'b1;
                    pred_byte = ref_q.pop_front();
                    exp_txd   = pred_byte;
                    exp_issue_q.push_back(pred_byte);
                    phase     = 1;
                    issue_cyc = cyc;
                end
                1: if (cyc >= issue_cyc + 2 && !TX_STATUS) phase = 2;
                2: if (TX_STATUS) begin
                    phase    = 0;
                    earliest = cyc + 1 + STOP;
                end
                default: phase = 0;
            endcase
            if (WR_EN && !full_pre) ref_q.push_back(WR_DATA);
        end
    end

    // Continuous comparison of all outputs against the reference model.
    always @(negedge sysclk) begin
        if (mon_en) begin
            if (TX_EN === 1'b1) en_cnt++;
            checks++;
            if (TX_EN !== pred_en) begin
                errors++;
                $display("FAIL mon_tx_en t=%0t got %b exp %b", $time, TX_EN, pred_en);
            end
            checks++;
            if (TX_DATA !== exp_txd) begin
                errors++;
                $display("FAIL mon_tx_data t=%0t got %h exp %h", $time, TX_DATA, exp_txd);
            end
            checks++;
            if (FULL !== (ref_q.size() == DEPTH) || EMPTY !== (ref_q.size() == 0)) begin
                errors++;
                $display("FAIL mon_flags t=%0t got full=%b empty=%b exp count %0d", $time, FULL, EMPTY, ref_q.size());
            end
            checks++;
            if (BUSY !== (ref_q.size() != 0 || phase != 0)) begin
                errors++;
                $display("FAIL mon_busy t=%0t got %b exp %b", $time, BUSY, (ref_q.size() != 0 || phase != 0));
            end
`ifdef UART_TXQ_LEVEL_EN
            checks++;
            if (LEVEL !== 3'(ref_q.size())) begin
                errors++;
                $display("FAIL mon_level t=%0t got %0d exp %0d", $time, LEVEL, ref_q.size());
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b);
        WR_DATA = b;
        WR_EN   = 1'b1;
        @(negedge sysclk);
        WR_EN   = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk);
            if (EMPTY === 1'b1 && BUSY === 1'b0 && !xm_busy && phase == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) repeat (3) @(negedge sysclk);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_issue_q.delete();
        accept_cyc.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge sysclk);
        mon_en = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++;
        if (TX_EN !== 1'b0 || TX_DATA !== 8'h00 || EMPTY !== 1'b1 || FULL !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got en=%b data=%h empty=%b full=%b busy=%b exp 0 00 1 0 0",
                     TX_EN, TX_DATA, EMPTY, FULL, BUSY);
        end
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_single();
        logic exp_line [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic got_line [10];
        clear_logs();
        push(8'hA5);
        checks++;
        if (TX_EN !== 1'b0) begin
            errors++;
            $display("FAIL single_edge0_en got %b exp 0", TX_EN);
        end
        @(negedge sysclk);
        checks++;
        if (TX_EN !== 1'b1 || TX_DATA !== 8'hA5) begin
            errors++;
            $display("FAIL single_issue got en=%b data=%h exp 1 a5", TX_EN, TX_DATA);
        end
        @(negedge sysclk);
        checks++;
        if (TX_EN !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width got %b exp 0", TX_EN);
        end
        got_line[0] = tx_line;
        for (int i = 1; i < 10; i++) begin
            @(negedge sysclk);
            got_line[i] = tx_line;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_line[i] !== exp_line[i]) begin
                errors++;
                $display("FAIL single_line bit %0d got %b exp %b", i, got_line[i], exp_line[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_idle(ok);
        clear_logs();
        en_cnt = 0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_timeout got busy exp idle");
        end
        checks++;
        if (rx_q.size() != 3 || en_cnt != 3) begin
            errors++;
            $display("FAIL b2b_count got frames=%0d pulses=%0d exp 3 3", rx_q.size(), en_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_order idx %0d got %h exp %h", i, rx_q[i], 8'(i + 1));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (accept_cyc[i] - accept_cyc[i-1] < 10 + STOP) begin
                    errors++;
                    $display("FAIL b2b_gap idx %0d got %0d exp >= %0d", i,
                             accept_cyc[i] - accept_cyc[i-1], 10 + STOP);
                end
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        logic [7:0] b [5];
        wait_idle(ok);
        clear_logs();
        force_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            push(b[i]);
            if (i == 3) begin
                checks++;
                if (FULL !== 1'b1) begin
                    errors++;
                    $display("FAIL full_after4 got %b exp 1", FULL);
                end
            end
        end
        checks++;
        if (FULL !== 1'b1 || EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL full_after5 got full=%b empty=%b exp 1 0", FULL, EMPTY);
        end
`ifdef UART_TXQ_LEVEL_EN
        checks++;
        if (LEVEL !== 3'd4) begin
            errors++;
            $display("FAIL full_level got %0d exp 4", LEVEL);
        end
`endif
        force_low = 1'b0;
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1 || rx_q.size() != 4) begin
            errors++;
            $display("FAIL full_drain got ok=%b frames=%0d exp 1 4", ok, rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[i] !== b[i]) begin
                    errors++;
                    $display("FAIL full_order idx %0d got %h exp %h", i, rx_q[i], b[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_idle(ok);
        clear_logs();
        force_high = 1'b1;
        en_cnt = 0;
        push(8'h5A);
        push(8'hC3);
        repeat (30) @(negedge sysclk);
        checks++;
        if (en_cnt != 1 || EMPTY !== 1'b0 || BUSY !== 1'b1 || xm_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall got pulses=%0d empty=%b busy=%b exp 1 0 1", en_cnt, EMPTY, BUSY);
        end
`ifdef UART_TXQ_LEVEL_EN
        checks++;
        if (LEVEL !== 3'd1) begin
            errors++;
            $display("FAIL stall_level got %0d exp 1", LEVEL);
        end
`endif
        reset = 1'b1;
        @(negedge sysclk);
        reset      = 1'b0;
        force_high = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int overrun = 0;
        logic [7:0] b0, nb;
        wait_idle(ok);
        clear_logs();
        b0 = 8'($urandom);
        nb = 8'($urandom);
        push(b0);
        push(8'($urandom));
        push(8'($urandom));
        repeat (3) @(negedge sysclk);
        checks++;
        if (xm_busy !== 1'b1 || EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL midframe_setup got xm_busy=%b empty=%b exp 1 0", xm_busy, EMPTY);
        end
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        checks++;
        if (EMPTY !== 1'b1 || TX_EN !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got empty=%b en=%b busy=%b exp 1 0 0", EMPTY, TX_EN, BUSY);
        end
        WR_DATA = nb;
        WR_EN   = 1'b1;
        @(negedge sysclk);
        WR_EN = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (TX_EN === 1'b1 && xm_busy) overrun++;
            @(negedge sysclk);
        end
        wait_idle(ok);
        checks++;
        if (overrun != 0) begin
            errors++;
            $display("FAIL midframe_overrun got %0d exp 0", overrun);
        end
        checks++;
        if (ok !== 1'b1 || rx_q.size() != 2 || rx_q[0] !== b0 || rx_q[1] !== nb) begin
            errors++;
            $display("FAIL midframe_frames got n=%0d exp 2 (%h %h)", rx_q.size(), b0, nb);
        end
    endtask

    task automatic test_push_pop();
        bit ok;
        logic [7:0] b [3];
        for (int r = 0; r < 3; r++) begin
            wait_idle(ok);
            clear_logs();
            for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
            force_low = 1'b1;
            push(b[0]);
            push(b[1]);
            force_low = 1'b0;
            push(b[2]);
            checks++;
            if (TX_EN !== 1'b1 || TX_DATA !== b[0] || EMPTY !== 1'b0 || FULL !== 1'b0) begin
                errors++;
                $display("FAIL pushpop_edge r%0d got en=%b data=%h exp 1 %h", r, TX_EN, TX_DATA, b[0]);
            end
`ifdef UART_TXQ_LEVEL_EN
            checks++;
            if (LEVEL !== 3'd2) begin
                errors++;
                $display("FAIL pushpop_level r%0d got %0d exp 2", r, LEVEL);
            end
`endif
            wait_idle(ok);
            checks++;
            if (ok !== 1'b1 || rx_q.size() != 3 || rx_q[0] !== b[0] || rx_q[1] !== b[1] || rx_q[2] !== b[2]) begin
                errors++;
                $display("FAIL pushpop_order r%0d got n=%0d exp 3 (%h %h %h)", r, rx_q.size(), b[0], b[1], b[2]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        wait_idle(ok);
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            WR_EN   = ($urandom_range(0, 2) == 0);
            WR_DATA = 8'($urandom);
            @(negedge sysclk);
        end
        WR_EN = 1'b0;
        wait_idle(ok);
        checks++;
        if (ok !== 1'b1 || rx_q.size() != exp_issue_q.size() || rx_q.size() == 0) begin
            errors++;
            $display("FAIL random_count got ok=%b frames=%0d exp %0d", ok, rx_q.size(), exp_issue_q.size());
        end else begin
            for (int i = 0; i < rx_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_issue_q[i]) begin
                    errors++;
                    $display("FAIL random_data idx %0d got %h exp %h", i, rx_q[i], exp_issue_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_reset_midframe();
        test_push_pop();
        test_random();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
